subleq_seq: RTL



---
 rtl/subleq_seq_if.sv | 21 ++
 rtl/subleq_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/subleq_seq_if.sv
// -----------------------------------------------------------------------------
// subleq_seq_if
//   Control side of the single-port RAM used by the subleq machine.
//   master : the sequencer, which owns every control pin.
//   slave  : the passive RAM.
//   ope : direction, 1 = write, 0 = read
//   ctl : write strobe, active-low; the RAM writes on its rising edge
//   ena : chip enable, active-low
//   adr : 8-bit address
//   The 8-bit data bus is tri-stated, so it is kept as a plain inout port on
//   the modules. Both sides then resolve it at the level where it is wired.
// -----------------------------------------------------------------------------
interface subleq_seq_if;
  logic       ope;
  logic       ctl;
  logic       ena;
  logic [7:0] adr;

  modport master (output ope, ctl, ena, adr);
  modport slave  (input  ope, ctl, ena, adr);
endinterface

// File: rtl/subleq_seq.sv
// -----------------------------------------------------------------------------
// subleq_seq
//   Instruction sequencer for the subleq machine. Executes one SUBLEQ
//   instruction every 7 cycles (FA FB FC RA RB WR WE):
//     mem[B] <= mem[B] - mem[A]; if result <= 0 then PC <= C else PC <= PC+3
//   After the first start pulse it keeps running until reset.
//
//   Ports
//     clk     : system clock, rising edge
//     rst_n   : asynchronous active-low reset
//     start   : one-cycle pulse, honoured only in IDLE
//     busy    : high in every state except IDLE and HALT
//     halted  : high in HALT; tied to 0 when HALT is not built
//     pc      : current program counter
//     ram     : RAM control pins (subleq_seq_if.master)
//     ram_dat : RAM data bus, driven only while ram.ope = 1, else high-Z
//
//   Build option
//     SUBLEQ_HALT_EN : when defined, a taken branch to 0xFF enters HALT.
//                      HALT is left only through reset.
// -----------------------------------------------------------------------------
module subleq_seq (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               halted,
  output logic [7:0]         pc,
  subleq_seq_if.master       ram,
  inout  wire  [7:0]         ram_dat
);

  typedef enum logic [3:0] {
    IDLE,
    FA,
    FB,
    FC,
    RA,
    RB,
    WR,
    WE
`ifdef SUBLEQ_HALT_EN
    ,
    HALT
`endif
  } state_t;

  state_t     state, state_next;
  logic [7:0] a_q, b_q, c_q, opa_q, opb_q;
  logic [7:0] res;
  logic       take;
  logic       ope, ctl, ena;
  logic [7:0] adr;

  // Borrow is discarded: the result is plain 8-bit two's complement.
  assign res  = opb_q - opa_q;
  assign take = res[7] | (res == 8'h00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ope        = 1'b0;
    ctl        = 1'b1;
    ena        = 1'b0;
    adr        = 8'h00;
    unique case (state)
      IDLE: begin
        ena = 1'b1;
        if (start) state_next = FA;
      end
      FA: begin adr = pc;          state_next = FB; end
      FB: begin adr = pc + 8'd1;   state_next = FC; end
      FC: begin adr = pc + 8'd2;   state_next = RA; end
      RA: begin adr = a_q;         state_next = RB; end
      RB: begin adr = b_q;         state_next = WR; end
      WR: begin
        adr        = b_q;
        ope        = 1'b1;
        ctl        = 1'b0;
        state_next = WE;
      end
      WE: begin
        // Address and data stay put while ctl rises, committing the write.
        adr        = b_q;
        ope        = 1'b1;
        state_next = FA;
`ifdef SUBLEQ_HALT_EN
        if (take && c_q == 8'hFF) state_next = HALT;
`endif
      end
`ifdef SUBLEQ_HALT_EN
      HALT: ena = 1'b1;
`endif
      default: begin
        ena        = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // Fetched words and operands are sampled at the exit edge of the state
  // that presented their address; the RAM read path is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= 8'h00;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      c_q   <= 8'h00;
      opa_q <= 8'h00;
      opb_q <= 8'h00;
    end else begin
      case (state)
        FA: a_q   <= ram_dat;
        FB: b_q   <= ram_dat;
        FC: c_q   <= ram_dat;
        RA: opa_q <= ram_dat;
        RB: opb_q <= ram_dat;
        WE: pc    <= take ? c_q : pc + 8'd3;
        default: ;
      endcase
    end
  end

  assign ram.ope = ope;
  assign ram.ctl = ctl;
  assign ram.ena = ena;
  assign ram.adr = adr;
  assign ram_dat = ope ? res : 8'hzz;

`ifdef SUBLEQ_HALT_EN
  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);
`else
  assign busy   = (state != IDLE);
  assign halted = 1'b0;
`endif

endmodule
